// File: rtl/lane_scheduler.sv
// Four-lane traffic scheduler: round-robin green bursts per lane,
// each followed by a yellow phase and an all-red gap.
module lane_scheduler #(
    parameter int GREEN_PER_CAR = 4,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1,
    parameter int MAX_BURST     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] lane_sel,
    input  logic [3:0] lane_cap,
    input  logic       start,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [4:0] state_ae,
    output logic [3:0] remaining,
    output logic [3:0] lane_empty,
    output logic       busy,
    output logic       done
);

    localparam int TMAX_GY = (GREEN_PER_CAR > YELLOW_CYCLES) ? GREEN_PER_CAR : YELLOW_CYCLES;
    localparam int TMAX    = (TMAX_GY > ALLRED_CYCLES) ? TMAX_GY : ALLRED_CYCLES;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW      = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_ALLRED
    } state_t;

    state_t          state_q;
    logic [1:0]      cur_q;
    logic [3:0]      cnt_q [4];
    logic [TW-1:0]   timer_q;
    logic [BW-1:0]   burst_q;
    logic            done_q;

    logic            sel_found;
    logic [1:0]      sel_lane;

    // Search for the next nonzero lane after cur, visiting cur itself last
    always_comb begin
        logic [1:0] idx;
        sel_found = 1'b0;
        sel_lane  = cur_q;
        idx       = cur_q;
        for (int k = 1; k <= 4; k++) begin
            idx = cur_q + 2'(k);
            if (!sel_found && cnt_q[idx] != 4'd0) begin
                sel_found = 1'b1;
                sel_lane  = idx;
            end
        end
    end

    // Phase sequencer, lane counts, timer and burst tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= 2'd3;
            for (int i = 0; i < 4; i++) cnt_q[i] <= 4'd0;
            timer_q <= '0;
            burst_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (load) begin
                        cnt_q[lane_sel] <= lane_cap;
                    end else if (start) begin
                        if (sel_found) begin
                            state_q <= S_GREEN;
                            cur_q   <= sel_lane;
                            timer_q <= '0;
                            burst_q <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_GREEN: begin
                    if (timer_q == TW'(GREEN_PER_CAR - 1)) begin
                        timer_q <= '0;
                        burst_q <= burst_q + BW'(1);
                        if (cnt_q[cur_q] != 4'd0) begin
                            cnt_q[cur_q] <= cnt_q[cur_q] - 4'd1;
                        end
                        if (cnt_q[cur_q] <= 4'd1 ||
                            burst_q == BW'(MAX_BURST - 1)) begin
                            state_q <= S_YELLOW;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_YELLOW: begin
                    if (timer_q == TW'(YELLOW_CYCLES - 1)) begin
                        timer_q <= '0;
                        state_q <= S_ALLRED;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_ALLRED: begin
                    if (timer_q == TW'(ALLRED_CYCLES - 1)) begin
                        timer_q <= '0;
                        if (sel_found) begin
                            state_q <= S_GREEN;
                            cur_q   <= sel_lane;
                            burst_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Per-lane empty flags straight from the count registers
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_empty[i] = (cnt_q[i] == 4'd0);
        end
    end

    assign green     = (state_q == S_GREEN)  ? (4'b0001 << cur_q) : 4'b0000;
    assign yellow    = (state_q == S_YELLOW) ? (4'b0001 << cur_q) : 4'b0000;
    assign state_ae  = (state_q == S_IDLE) ? 5'b00001
                                           : {(4'b0001 << cur_q), 1'b0};
    assign remaining = (state_q == S_IDLE) ? 4'd0 : cnt_q[cur_q];
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule
